// File: rtl/instr_fetch_unit.sv
// Fetch engine: owns the PC, issues one-cycle-latency instruction memory reads
// and buffers up to two {pc, instr} pairs for decode over valid/ready.
module instr_fetch_unit #(
  parameter int          NUM_INSTR = 32,
  parameter int unsigned RESET_PC  = 0,
  localparam int         ADDR_W    = $clog2(NUM_INSTR) * 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign pop       = (count_reg != 2'd0) && out_ready;
  assign push      = inflight_reg;
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg};
  // Reserve a FIFO slot for every outstanding fetch so responses never overflow.
  assign issue     = !redirect_valid && (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_ADDR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      if (issue) begin
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + ADDR_W'(4);
      end else begin
        inflight_reg <= 1'b0;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      assert (!(push && !pop && count_reg == 2'd2));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [ADDR_W-1:0] pc_reg;
      logic [31:0]       instr_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          pc_reg    <= '0;
          instr_reg <= '0;
        end else if (push && !redirect_valid && (wr_ptr_reg == 1'(gi))) begin
          pc_reg    <= inflight_pc_reg;
          instr_reg <= imem_instr;
        end
      end
    end
  endgenerate

  assign imem_addr = fetch_pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_pc    = rd_ptr_reg ? g_entry[1].pc_reg    : g_entry[0].pc_reg;
  assign out_instr = rd_ptr_reg ? g_entry[1].instr_reg : g_entry[0].instr_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected PCs that
// is checked on every accepted handshake; a second instance covers PC wrap.
module tb_instr_fetch_unit;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr, imem_addr2;
  logic [31:0]   imem_instr, imem_instr2;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid, out_valid2;
  logic          out_ready;
  logic [31:0]   out_instr, out_instr2;
  logic [AW-1:0] out_pc, out_pc2;

  logic [AW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch_unit #(.NUM_INSTR(32), .RESET_PC(32'h000F_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(20'h0),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_instr(out_instr2), .out_pc(out_pc2)
  );

  // Synchronous memory model: word tags the address so pc/instr mixups show.
  always @(posedge clk) begin
    imem_instr  <= {12'hA5C, imem_addr};
    imem_instr2 <= {12'hA5C, imem_addr2};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_run(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + AW'(4 * i));
  endtask

  // Drive one cycle of inputs, score any handshake, then advance to the next cycle.
  task automatic cycle(input logic rdy, input logic rv, input logic [AW-1:0] rpc);
    logic [AW-1:0] exp_pc;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=handshake pc=0x%0h expected=no_output", out_pc);
      end
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        $display("txn pc=0x%05h instr=0x%08h expected_pc=0x%05h", out_pc, out_instr, exp_pc);
        chk("sb_pc", 32'(out_pc), 32'(exp_pc));
        chk("sb_instr", out_instr, {12'hA5C, exp_pc});
      end
    end
    if (rv) load_run({rpc[AW-1:2], 2'b00});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_addr_wrap", 32'(imem_addr2), 32'h000F_FFF8);
    chk("rst_valid_wrap", 32'(out_valid2), 32'd0);

    // Streaming from reset, then a stall of cycles 3..8.
    load_run('0);
    rst = 1'b0;
    chk("c0_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("c1_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("c2_valid", 32'(out_valid), 32'd1);
    chk("c2_pc", 32'(out_pc), 32'd0);
    chk("wrap_pc0", 32'(out_pc2), 32'h000F_FFF8);
    chk("wrap_valid", 32'(out_valid2), 32'd1);
    cycle(1'b1, 1'b0, '0);
    for (int k = 3; k <= 8; k++) begin
      if (k == 3) chk("wrap_pc1", 32'(out_pc2), 32'h000F_FFFC);
      if (k == 4) chk("wrap_pc2", 32'(out_pc2), 32'h0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", 32'(out_pc), 32'd4);
      cycle(1'b0, 1'b0, '0);
    end
    chk("stall_addr", 32'(imem_addr), 32'd12);
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, '0);

    // Redirect to 0x40 with a full buffer.
    cycle(1'b0, 1'b0, '0);
    chk("rA_full_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, 1'b1, 20'h00040);
    chk("rA_n1_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rA_n2_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rA_n3_valid", 32'(out_valid), 32'd1);
    chk("rA_n3_pc", 32'(out_pc), 32'h40);
    cycle(1'b1, 1'b0, '0);
    chk("rA_n4_pc", 32'(out_pc), 32'h44);
    cycle(1'b1, 1'b0, '0);

    // Redirect with an accepted handshake; misaligned targets are aligned down.
    cycle(1'b1, 1'b1, 20'h00001);
    chk("rB_n1_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rB_n2_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rB_n3_pc", 32'(out_pc), 32'h0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("rB_hs_pc", 32'(out_pc), 32'h8);
    cycle(1'b1, 1'b1, 20'h00043);
    chk("rC_n1_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rC_n2_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rC_n3_valid", 32'(out_valid), 32'd1);
    chk("rC_n3_pc", 32'(out_pc), 32'h40);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, '0);

    // Reset in the middle of a full buffer.
    cycle(1'b0, 1'b0, '0);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_pc", 32'(out_pc), 32'd0);
    chk("rm_instr", out_instr, 32'd0);
    chk("rm_addr", 32'(imem_addr), 32'd0);
    load_run('0);
    rst = 1'b0;
    chk("rm_c0_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rm_c1_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("rm_c2_valid", 32'(out_valid), 32'd1);
    chk("rm_c2_pc", 32'(out_pc), 32'd0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, '0);
    chk("rm_stream_pc", 32'(out_pc), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Datapath-side fetch engine for the instruction memory interface. Owns the program counter, drives the instruction address toward the instruction memory, captures the returned instruction one cycle later, and presents `{pc, instr}` pairs to decode over a valid/ready handshake. It buffers up to two instructions so decode back-pressure never drops a fetch. It also supports a redirect (branch/jump) with flush of stale fetches.

## Interface
Parameters:
- `NUM_INSTR`, 32: instruction memory depth; the address width is derived as `ADDR_W = $clog2(NUM_INSTR)*4`, which gives 20 for the default.
- `RESET_PC`, 0: PC loaded on reset. It must be 4-byte aligned.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `imem_addr`, out, `ADDR_W`: fetch address to instruction memory. It is a registered copy of the fetch PC.
- `imem_instr`, in, `InstructionSize` (32): memory read data. It is valid in cycle N+1 for the address presented in cycle N.
- `redirect_valid`, in, 1: pulse that replaces the fetch PC and flushes.
- `redirect_pc`, in, `ADDR_W`: target PC. Bits [1:0] are ignored and treated as 0.
- `out_valid`, out, 1: head of the buffer is valid.
- `out_ready`, in, 1: decode accepts the head.
- `out_instr`, out, 32: instruction at the head.
- `out_pc`, out, `ADDR_W`: PC of `out_instr`.

## Operation
State:
- `fetch_pc`: drives `imem_addr`.
- `inflight`: 1 bit, plus `inflight_pc`.
- 2-entry FIFO of `{pc, instr}` with `count` in 0..2.

Per-cycle rules:
- `pop = out_valid & out_ready`.
- `issue = !redirect_valid & (count + inflight - pop < 2)`.
- On issue, `imem_addr` in this cycle is a live request: set `inflight` = 1 and `inflight_pc` = `fetch_pc`, then `fetch_pc <= fetch_pc + 4`.
- With no issue, `fetch_pc` holds, `inflight` is cleared, and the memory response next cycle is ignored.
- A response arrives in the cycle after an issue with `inflight` = 1. `{inflight_pc, imem_instr}` is written to the FIFO tail at the end of that cycle.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- The issue condition guarantees a push never targets a full FIFO. Overflow is an assertion failure.
- Outputs: `out_valid = (count != 0)`; `out_instr` and `out_pc` come from the FIFO head. They are stable while `out_valid & !out_ready`.
- PC arithmetic is modulo 2^`ADDR_W`. The PC wraps from max-4 to 0 silently.

Redirect (`redirect_valid` = 1 in cycle N):
- The handshake in cycle N still completes if `out_valid & out_ready`; decode owns that instruction.
- At the end of cycle N, the FIFO is cleared (`count` = 0), `inflight` is cleared so the N+1 response is discarded, and `fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
- There is no issue in cycle N.
- Back-to-back redirects: the last one wins.

Reset (`rst` high at an edge):
- `fetch_pc` = `imem_addr` = `RESET_PC`, `inflight` = 0, `count` = 0, `out_valid` = 0.
- `out_instr` and `out_pc` are 0.
- Reset overrides redirect and any in-flight fetch.

## Timing
- Cycle 0 is the first cycle with `rst` low: the issue is at `RESET_PC` and the response arrives in cycle 1. `out_valid` = 1 in cycle 2 with `out_pc` = `RESET_PC`.
- Fetch-to-decode latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle with `out_ready` held high (steady state `count` = 1, `inflight` = 1).
- Redirect in cycle N: `out_valid` = 0 in cycles N+1 and N+2. The first target instruction has `out_valid` = 1 in cycle N+3.
- Back-pressure: with `out_ready` low, the buffer fills to `count` = 2 and issue stops. There is no gap: after `out_ready` rises, output is consecutive with no lost or duplicated PCs.
- No combinational path from `out_ready` or `redirect_valid` to `imem_addr`. `out_*` are registered.

## Test plan
- Reset then `out_ready` = 1, memory word = addr: `out_valid` first in cycle 2. `out_pc` sequence is 0, 4, 8, … on consecutive cycles, and `out_instr` matches.
- Back-pressure: `out_ready` low for cycles 3–8 then high. `out_pc` holds 4 while stalled, then continues 8, 12, … with no skips or duplicates; `count` never exceeds 2.
- Redirect to 0x40 while `count` = 2 and `inflight` = 1: stale entries are never presented. `out_valid` is low for 2 cycles, then `out_pc` is 0x40, 0x44.
- Redirect in the same cycle as an accepted handshake at `pc` 0x8: 0x8 is consumed exactly once. The next presented PC is the target. `redirect_pc` = 0x43 yields 0x40.
- Wrap: `RESET_PC` = 2^20−8 yields `out_pc` 0xFFFF8, 0xFFFFC, 0x00000.
- Reset asserted mid-stream with `inflight` = 1 and `count` = 2: `out_valid` = 0 the next cycle and the stream restarts at `RESET_PC`.
